// File: rtl/tl_fifo_fixer_ordered.sv
// TileLink-UL FIFO fixer: holds a new request from a source while that source still has
// requests outstanding to a different FIFO domain or is at its outstanding limit.
module tl_fifo_fixer_ordered #(
    parameter int unsigned SOURCE_BITS  = 3,
    parameter int unsigned ADDR_BITS    = 31,
    parameter int unsigned DATA_BITS    = 64,
    parameter int unsigned DOMAIN_SHIFT = 28,
    parameter int unsigned DOMAIN_BITS  = 2,
    parameter int unsigned MAX_OUT      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     auto_in_a_ready,
    input  logic                     auto_in_a_valid,
    input  logic [2:0]               auto_in_a_bits_opcode,
    input  logic [2:0]               auto_in_a_bits_param,
    input  logic [2:0]               auto_in_a_bits_size,
    input  logic [SOURCE_BITS-1:0]   auto_in_a_bits_source,
    input  logic [ADDR_BITS-1:0]     auto_in_a_bits_address,
    input  logic [DATA_BITS/8-1:0]   auto_in_a_bits_mask,
    input  logic [DATA_BITS-1:0]     auto_in_a_bits_data,
    input  logic                     auto_in_a_bits_corrupt,
    input  logic                     auto_in_d_ready,
    output logic                     auto_in_d_valid,
    output logic [2:0]               auto_in_d_bits_opcode,
    output logic [2:0]               auto_in_d_bits_size,
    output logic [SOURCE_BITS-1:0]   auto_in_d_bits_source,
    output logic [DATA_BITS-1:0]     auto_in_d_bits_data,
    input  logic                     auto_out_a_ready,
    output logic                     auto_out_a_valid,
    output logic [2:0]               auto_out_a_bits_opcode,
    output logic [2:0]               auto_out_a_bits_param,
    output logic [2:0]               auto_out_a_bits_size,
    output logic [SOURCE_BITS-1:0]   auto_out_a_bits_source,
    output logic [ADDR_BITS-1:0]     auto_out_a_bits_address,
    output logic [DATA_BITS/8-1:0]   auto_out_a_bits_mask,
    output logic [DATA_BITS-1:0]     auto_out_a_bits_data,
    output logic                     auto_out_a_bits_corrupt,
    output logic                     auto_out_d_ready,
    input  logic                     auto_out_d_valid,
    input  logic [2:0]               auto_out_d_bits_opcode,
    input  logic [2:0]               auto_out_d_bits_size,
    input  logic [SOURCE_BITS-1:0]   auto_out_d_bits_source,
    input  logic [DATA_BITS-1:0]     auto_out_d_bits_data,
    output logic                     stall_active
);

    localparam int unsigned NUM_SRC = 1 << SOURCE_BITS;
    localparam int          LOG_BEAT = $clog2(DATA_BITS / 8);

    // Largest burst is 128 bytes at 8-bit data, so 8 bits of beat count suffice.
    function automatic logic [7:0] beats_of(input logic has_data, input logic [2:0] size);
        if (has_data && int'(size) > LOG_BEAT) begin
            return 8'd1 << (int'(size) - LOG_BEAT);
        end
        return 8'd1;
    endfunction

    logic [3:0]             flight_q [NUM_SRC];
    logic [3:0]             flight_d [NUM_SRC];
    logic [DOMAIN_BITS-1:0] dom_q    [NUM_SRC];
    logic [DOMAIN_BITS-1:0] dom_d    [NUM_SRC];
    logic [7:0]             a_beat_q, a_beat_d, d_beat_q, d_beat_d;
    logic [7:0]             a_beats, d_beats;
    logic [DOMAIN_BITS-1:0] a_dom;
    logic [SOURCE_BITS-1:0] a_src, d_src;
    logic                   a_first, d_first, d_last, stall, a_fire, d_fire;
    logic [NUM_SRC-1:0]     inc, dec;

    assign a_dom   = auto_in_a_bits_address[DOMAIN_SHIFT +: DOMAIN_BITS];
    assign a_src   = auto_in_a_bits_source;
    assign d_src   = auto_out_d_bits_source;
    assign a_beats = beats_of(~auto_in_a_bits_opcode[2], auto_in_a_bits_size);
    assign d_beats = beats_of(auto_out_d_bits_opcode == 3'd1, auto_out_d_bits_size);
    assign a_first = (a_beat_q == 8'd0);
    assign d_first = (d_beat_q == 8'd0);
    assign d_last  = d_first ? (d_beats == 8'd1) : (d_beat_q == 8'd1);

    assign stall = a_first &&
                   (((flight_q[a_src] != 4'd0) && (dom_q[a_src] != a_dom)) ||
                    (flight_q[a_src] == 4'(MAX_OUT)));

    assign a_fire = auto_in_a_valid && auto_out_a_ready && !stall;
    assign d_fire = auto_out_d_valid && auto_in_d_ready;

    assign auto_out_a_valid = auto_in_a_valid & ~stall;
    assign auto_in_a_ready  = auto_out_a_ready & ~stall;
    assign stall_active     = auto_in_a_valid & stall;

    assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
    assign auto_out_a_bits_param   = auto_in_a_bits_param;
    assign auto_out_a_bits_size    = auto_in_a_bits_size;
    assign auto_out_a_bits_source  = auto_in_a_bits_source;
    assign auto_out_a_bits_address = auto_in_a_bits_address;
    assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
    assign auto_out_a_bits_data    = auto_in_a_bits_data;
    assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

    assign auto_out_d_ready      = auto_in_d_ready;
    assign auto_in_d_valid       = auto_out_d_valid;
    assign auto_in_d_bits_opcode = auto_out_d_bits_opcode;
    assign auto_in_d_bits_size   = auto_out_d_bits_size;
    assign auto_in_d_bits_source = auto_out_d_bits_source;
    assign auto_in_d_bits_data   = auto_out_d_bits_data;

    always_comb begin
        a_beat_d = a_beat_q;
        d_beat_d = d_beat_q;
        if (a_fire) begin
            a_beat_d = a_first ? a_beats - 8'd1 : a_beat_q - 8'd1;
        end
        if (d_fire) begin
            d_beat_d = d_first ? d_beats - 8'd1 : d_beat_q - 8'd1;
        end
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            flight_d[s] = flight_q[s];
            dom_d[s]    = dom_q[s];
            inc[s] = a_fire && a_first && (a_src == SOURCE_BITS'(s));
            dec[s] = d_fire && d_last && (d_src == SOURCE_BITS'(s));
            if (inc[s]) begin
                dom_d[s] = a_dom;
            end
            // A same-cycle issue and retire cancel out.
            if (inc[s] && !dec[s]) begin
                flight_d[s] = flight_q[s] + 4'd1;
            end else if (dec[s] && !inc[s] && flight_q[s] != 4'd0) begin
                flight_d[s] = flight_q[s] - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_beat_q <= 8'd0;
            d_beat_q <= 8'd0;
            for (int s = 0; s < NUM_SRC; s++) begin
                flight_q[s] <= 4'd0;
                dom_q[s]    <= '0;
            end
        end else begin
            a_beat_q <= a_beat_d;
            d_beat_q <= d_beat_d;
            for (int s = 0; s < NUM_SRC; s++) begin
                flight_q[s] <= flight_d[s];
                dom_q[s]    <= dom_d[s];
            end
        end
    end

endmodule
